// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - song ROM stepper that turns note codes into half-period dividers
// Walks the song one entry per beat and drives registered divider/noise/volume outputs.
module tone_sequencer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BEAT_HZ  = 8,
    parameter int GAP_CYC  = (CLK_HZ / BEAT_HZ) / 8,
    parameter int SONG_LEN = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_play,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loop_en,
    input  logic              i_vol_up,
    input  logic              i_vol_down,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [5:0]        i_rom_data_l,
    input  logic [5:0]        i_rom_data_r,
    output logic [21:0]       o_note_div_left,
    output logic [21:0]       o_note_div_right,
    output logic              o_is_noise,
    output logic [2:0]        o_volume,
    output logic              o_beat_tick,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
    localparam int CNT_W    = $clog2(BEAT_CYC + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_START = CNT_W'(BEAT_CYC - GAP_CYC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [21:0]       r_note_l, r_note_r, w_note_l, w_note_r;
    logic              r_noise_l, r_noise_r, w_noise_l, w_noise_r;
    logic [22:0]       w_dec_l, w_dec_r;
    logic              w_sound, w_tick_nxt, w_done_nxt;
    logic [21:0]       r_div_l, r_div_r;
    logic              r_is_noise, r_beat_tick, r_done;
    logic [2:0]        r_vol;

    // {is_noise, divider}; base table is octave 3, higher octaves halve the period
    function automatic logic [22:0] decode_note(input logic [5:0] code);
        logic [21:0] base;
        logic        noise;
        logic        rest;
        base  = 22'd0;
        noise = 1'b0;
        rest  = 1'b0;
        case (code[3:0])
            4'd0:    base = 22'd382224;
            4'd1:    base = 22'd360772;
            4'd2:    base = 22'd340524;
            4'd3:    base = 22'd321412;
            4'd4:    base = 22'd303371;
            4'd5:    base = 22'd286344;
            4'd6:    base = 22'd270273;
            4'd7:    base = 22'd255103;
            4'd8:    base = 22'd240786;
            4'd9:    base = 22'd227271;
            4'd10:   base = 22'd214515;
            4'd11:   base = 22'd202475;
            4'd13:   noise = 1'b1;
            default: rest = 1'b1;
        endcase
        if (noise)
            return {1'b1, 22'd2};
        else if (rest)
            return {1'b0, 22'd1};
        else
            return {1'b0, base >> code[5:4]};
    endfunction

    assign w_dec_l = decode_note(i_rom_data_l);
    assign w_dec_r = decode_note(i_rom_data_r);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_play && !i_stop) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = '0;
                end
            end
            S_FETCH: w_state_nxt = i_stop ? S_IDLE : S_LOAD;
            S_LOAD: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PLAY;
                    w_cnt_nxt   = '0;
                end
            end
            S_PLAY: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt = '0;
                    if (r_addr != LAST_ADDR) begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (i_loop_en) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PAUSE: begin
                if (i_stop)
                    w_state_nxt = S_IDLE;
                else if (i_pause)
                    w_state_nxt = S_PLAY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The freshly read codes bypass the latch so the note appears on the first PLAY cycle
    assign w_note_l  = (r_state == S_LOAD) ? w_dec_l[21:0] : r_note_l;
    assign w_note_r  = (r_state == S_LOAD) ? w_dec_r[21:0] : r_note_r;
    assign w_noise_l = (r_state == S_LOAD) ? w_dec_l[22] : r_noise_l;
    assign w_noise_r = (r_state == S_LOAD) ? w_dec_r[22] : r_noise_r;
    assign w_sound    = (w_state_nxt == S_PLAY) && (w_cnt_nxt < GAP_START);
    assign w_tick_nxt = (w_state_nxt == S_PLAY) && (w_cnt_nxt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_note_l    <= 22'd1;
            r_note_r    <= 22'd1;
            r_noise_l   <= 1'b0;
            r_noise_r   <= 1'b0;
            r_div_l     <= 22'd1;
            r_div_r     <= 22'd1;
            r_is_noise  <= 1'b0;
            r_beat_tick <= 1'b0;
            r_done      <= 1'b0;
            r_vol       <= 3'd3;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_note_l    <= w_note_l;
            r_note_r    <= w_note_r;
            r_noise_l   <= w_noise_l;
            r_noise_r   <= w_noise_r;
            r_div_l     <= w_sound ? w_note_l : 22'd1;
            r_div_r     <= w_sound ? w_note_r : 22'd1;
            r_is_noise  <= w_sound && (w_noise_l || w_noise_r);
            r_beat_tick <= w_tick_nxt;
            r_done      <= w_done_nxt;
            if (i_vol_up && !i_vol_down && r_vol != 3'd5)
                r_vol <= r_vol + 3'd1;
            else if (i_vol_down && !i_vol_up && r_vol != 3'd1)
                r_vol <= r_vol - 3'd1;
        end
    end

    assign o_rom_addr       = r_addr;
    assign o_note_div_left  = r_div_l;
    assign o_note_div_right = r_div_r;
    assign o_is_noise       = r_is_noise;
    assign o_volume         = r_vol;
    assign o_beat_tick      = r_beat_tick;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - directed scoreboard bench for tone_sequencer
module tb_tone_sequencer;

    logic        clk;
    logic        rst;
    logic        i_play, i_stop, i_pause, i_loop_en, i_vol_up, i_vol_down;
    logic [1:0]  o_rom_addr;
    logic [5:0]  i_rom_data_l, i_rom_data_r;
    logic [21:0] o_note_div_left, o_note_div_right;
    logic        o_is_noise;
    logic [2:0]  o_volume;
    logic        o_beat_tick, o_busy, o_done;

    tone_sequencer #(
        .CLK_HZ(1000), .BEAT_HZ(100), .GAP_CYC(2), .SONG_LEN(4), .ADDR_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_play(i_play), .i_stop(i_stop), .i_pause(i_pause), .i_loop_en(i_loop_en),
        .i_vol_up(i_vol_up), .i_vol_down(i_vol_down),
        .o_rom_addr(o_rom_addr), .i_rom_data_l(i_rom_data_l), .i_rom_data_r(i_rom_data_r),
        .o_note_div_left(o_note_div_left), .o_note_div_right(o_note_div_right),
        .o_is_noise(o_is_noise), .o_volume(o_volume), .o_beat_tick(o_beat_tick),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] rom_l [4];
    logic [5:0] rom_r [4];
    initial begin
        rom_l[0] = 6'h09; rom_l[1] = 6'h19; rom_l[2] = 6'h0C; rom_l[3] = 6'h0D;
        for (int i = 0; i < 4; i++) rom_r[i] = 6'h00;
    end
    always @(posedge clk) begin
        i_rom_data_l <= rom_l[o_rom_addr];
        i_rom_data_r <= rom_r[o_rom_addr];
    end

    typedef struct {
        int div_l;
        int div_r;
        int noise;
        int addr;
    } beat_t;
    beat_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int dl, input int dr, input int nz, input int ad);
        beat_t b;
        b.div_l = dl; b.div_r = dr; b.noise = nz; b.addr = ad;
        sb.push_back(b);
    endtask

    task automatic push_song();
        push_beat(227271, 382224, 0, 0);
        push_beat(113635, 382224, 0, 1);
        push_beat(1,      382224, 0, 2);
        push_beat(2,      382224, 1, 3);
    endtask

    task automatic pulse_play();
        i_play = 1'b1;
        tick();
        i_play = 1'b0;
    endtask

    // Entered at the FETCH negedge; walks FETCH, LOAD and ten PLAY cycles.
    task automatic check_beat();
        beat_t e;
        bit    snd;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_underflow observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < 12; c++) begin
            snd = (c >= 2) && (c <= 9);
            if (c == 0) begin
                chk($sformatf("b%0d_fetch_addr", e.addr), 32'(o_rom_addr), e.addr);
                chk($sformatf("b%0d_fetch_done", e.addr), 32'(o_done), 0);
            end
            chk($sformatf("b%0d_c%0d_div_l", e.addr, c), 32'(o_note_div_left), snd ? e.div_l : 1);
            chk($sformatf("b%0d_c%0d_div_r", e.addr, c), 32'(o_note_div_right), snd ? e.div_r : 1);
            chk($sformatf("b%0d_c%0d_noise", e.addr, c), 32'(o_is_noise), snd ? e.noise : 0);
            chk($sformatf("b%0d_c%0d_tick", e.addr, c), 32'(o_beat_tick), (c == 11) ? 1 : 0);
            chk($sformatf("b%0d_c%0d_busy", e.addr, c), 32'(o_busy), 1);
            tick();
        end
    endtask

    int v;

    initial begin
        rst = 1'b1;
        i_play = 0; i_stop = 0; i_pause = 0; i_loop_en = 0; i_vol_up = 0; i_vol_down = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_addr", 32'(o_rom_addr), 0);
        chk("rst_div_l", 32'(o_note_div_left), 1);
        chk("rst_div_r", 32'(o_note_div_right), 1);
        chk("rst_noise", 32'(o_is_noise), 0);
        chk("rst_volume", 32'(o_volume), 3);
        chk("rst_tick", 32'(o_beat_tick), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);

        // one pass through the song, no loop
        push_song();
        pulse_play();
        repeat (4) check_beat();
        chk("end_done", 32'(o_done), 1);
        chk("end_busy", 32'(o_busy), 0);
        chk("end_div_l", 32'(o_note_div_left), 1);
        tick();
        chk("end_done_pulse", 32'(o_done), 0);

        // looping: entry 0 reloads after entry 3, done stays low
        i_loop_en = 1'b1;
        push_song();
        push_beat(227271, 382224, 0, 0);
        pulse_play();
        repeat (5) check_beat();
        chk("loop_addr_next", 32'(o_rom_addr), 1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        i_loop_en = 1'b0;
        chk("loop_stop_busy", 32'(o_busy), 0);
        chk("loop_stop_div", 32'(o_note_div_left), 1);
        chk("loop_stop_done", 32'(o_done), 0);

        // pause at PLAY count 4 for 20 cycles
        pulse_play();
        tick();
        tick();
        chk("pz_cnt0_div", 32'(o_note_div_left), 227271);
        repeat (4) tick();
        chk("pz_cnt4_div", 32'(o_note_div_left), 227271);
        i_pause = 1'b1;
        tick();
        i_pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("pz_hold%0d_div_l", i), 32'(o_note_div_left), 1);
            chk($sformatf("pz_hold%0d_div_r", i), 32'(o_note_div_right), 1);
            chk($sformatf("pz_hold%0d_tick", i), 32'(o_beat_tick), 0);
            chk($sformatf("pz_hold%0d_busy", i), 32'(o_busy), 1);
            if (i == 19) i_pause = 1'b1;
            tick();
        end
        i_pause = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("pz_res%0d_div", k), 32'(o_note_div_left), (k < 4) ? 227271 : 1);
            chk($sformatf("pz_res%0d_tick", k), 32'(o_beat_tick), (k == 5) ? 1 : 0);
            tick();
        end
        chk("pz_next_addr", 32'(o_rom_addr), 1);
        chk("pz_next_busy", 32'(o_busy), 1);
        tick();
        tick();
        chk("sp_note_div", 32'(o_note_div_left), 113635);
        i_stop = 1'b1;
        i_pause = 1'b1;
        tick();
        i_stop = 1'b0;
        i_pause = 1'b0;
        chk("sp_busy", 32'(o_busy), 0);
        chk("sp_div", 32'(o_note_div_left), 1);
        chk("sp_done", 32'(o_done), 0);
        tick();
        chk("sp_still_idle", 32'(o_busy), 0);

        // volume saturation
        v = 3;
        repeat (6) begin
            i_vol_up = 1'b1;
            tick();
            i_vol_up = 1'b0;
            v = (v < 5) ? v + 1 : 5;
            chk("vol_up", 32'(o_volume), v);
        end
        repeat (6) begin
            i_vol_down = 1'b1;
            tick();
            i_vol_down = 1'b0;
            v = (v > 1) ? v - 1 : 1;
            chk("vol_down", 32'(o_volume), v);
        end
        i_vol_up = 1'b1; i_vol_down = 1'b1;
        tick();
        i_vol_up = 1'b0; i_vol_down = 1'b0;
        chk("vol_both_at1", 32'(o_volume), v);
        i_vol_up = 1'b1;
        tick();
        i_vol_up = 1'b0;
        v = v + 1;
        chk("vol_up_once", 32'(o_volume), v);
        i_vol_up = 1'b1; i_vol_down = 1'b1;
        tick();
        i_vol_up = 1'b0; i_vol_down = 1'b0;
        chk("vol_both_mid", 32'(o_volume), v);

        // asynchronous reset in the middle of beat 1
        push_beat(227271, 382224, 0, 0);
        pulse_play();
        check_beat();
        tick();
        tick();
        chk("mr_pre_div", 32'(o_note_div_left), 113635);
        #2 rst = 1'b1;
        #1;
        chk("mr_addr", 32'(o_rom_addr), 0);
        chk("mr_div_l", 32'(o_note_div_left), 1);
        chk("mr_div_r", 32'(o_note_div_right), 1);
        chk("mr_noise", 32'(o_is_noise), 0);
        chk("mr_volume", 32'(o_volume), 3);
        chk("mr_tick", 32'(o_beat_tick), 0);
        chk("mr_busy", 32'(o_busy), 0);
        chk("mr_done", 32'(o_done), 0);
        tick();
        rst = 1'b0;
        tick();
        push_beat(227271, 382224, 0, 0);
        pulse_play();
        check_beat();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("final_idle", 32'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
